// File: rtl/game_ctrl.sv
// game_ctrl: frame-synchronous dinosaur-runner sequencer (state, collision, BCD score, speed).
// Define GAME_CTRL_HISCORE_EN to build the best-score register and comparator.
module game_ctrl #(
   parameter int unsigned SCORE_DIV   = 6,
   parameter logic [3:0]  INIT_SPEED  = 4'd1,
   parameter logic [3:0]  MAX_SPEED   = 4'd15,
   parameter logic [7:0]  COLLIDE_MIN = 8'd4
) (
   input  logic        CLK,
   input  logic        clrn,
   input  logic        start,
   input  logic        vs,
   input  logic        px_dinosaur,
   input  logic        px_cactus,
   output logic        game_status,
   output logic        game_over,
   output logic        frame_tick,
   output logic [3:0]  speed,
   output logic [15:0] score,
   output logic [15:0] hiscore
);

   localparam int unsigned FW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
   localparam logic [FW-1:0] LAST = FW'(SCORE_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_OVER = 2'b10,
      S_ILL  = 2'b11
   } state_e;

   state_e         state_q, state_d;
   logic           vs_d_q, vs_d_d;
   logic           tick_q, tick_d;
   logic           start_q, start_d;
   logic           pend_q, pend_d;
   logic [7:0]     hit_q, hit_d;
   logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
   logic [15:0]    score_q, score_d;
   logic [3:0]     speed_q, speed_d;

   logic           hit;
   logic           wait_start;
   logic           overlap;
   logic [15:0]    score_nx;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign hit        = (hit_q >= COLLIDE_MIN);
   assign wait_start = (state_q == S_IDLE) || (state_q == S_OVER);
   assign overlap    = px_dinosaur & px_cactus & vs;
   assign score_nx   = bcd_inc(score_q);

   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick_q) begin
         unique case (state_q)
            S_IDLE:  if (pend_q) state_d = S_RUN;
            S_RUN:   if (hit) state_d = S_OVER;
            S_OVER:  if (pend_q) state_d = S_RUN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      game_status = (state_q == S_RUN);
      game_over   = (state_q == S_OVER);
      frame_tick  = tick_q;
      speed       = speed_q;
      score       = score_q;
   end

   always_comb begin
      vs_d_d      = vs;
      tick_d      = vs_d_q & ~vs;
      start_d     = start;
      pend_d      = pend_q;
      hit_d       = hit_q;
      frame_cnt_d = frame_cnt_q;
      score_d     = score_q;
      speed_d     = speed_q;

      // consuming a request beats a fresh edge in the same cycle
      if (tick_q && pend_q && wait_start) begin
         pend_d = 1'b0;
      end else if (start && !start_q && wait_start) begin
         pend_d = 1'b1;
      end

      if (tick_q) begin
         hit_d = 8'd0;
      end else if (state_q == S_RUN && overlap && hit_q != 8'hFF) begin
         hit_d = hit_q + 8'd1;
      end

      if (tick_q) begin
         if (state_q == S_OVER && pend_q) begin
            score_d     = 16'h0000;
            frame_cnt_d = '0;
            speed_d     = INIT_SPEED;
         end else if (state_q == S_RUN && !hit) begin
            if (frame_cnt_q == LAST) begin
               frame_cnt_d = '0;
               if (score_q != 16'h9999) begin
                  score_d = score_nx;
                  if (score_nx[7:0] == 8'h00 && speed_q < MAX_SPEED) begin
                     speed_d = speed_q + 4'd1;
                  end
               end
            end else begin
               frame_cnt_d = frame_cnt_q + FW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) begin
         vs_d_q      <= 1'b0;
         tick_q      <= 1'b0;
         start_q     <= 1'b0;
         pend_q      <= 1'b0;
         hit_q       <= 8'd0;
         frame_cnt_q <= '0;
         score_q     <= 16'h0000;
         speed_q     <= INIT_SPEED;
      end else begin
         vs_d_q      <= vs_d_d;
         tick_q      <= tick_d;
         start_q     <= start_d;
         pend_q      <= pend_d;
         hit_q       <= hit_d;
         frame_cnt_q <= frame_cnt_d;
         score_q     <= score_d;
         speed_q     <= speed_d;
      end
   end

`ifdef GAME_CTRL_HISCORE_EN
   logic [15:0] hiscore_q, hiscore_d;

   // packed BCD orders the same as unsigned binary
   always_comb begin
      hiscore_d = hiscore_q;
      if (tick_q && state_q == S_RUN && hit && score_q > hiscore_q) begin
         hiscore_d = score_q;
      end
   end

   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) begin
         hiscore_q <= 16'h0000;
      end else begin
         hiscore_q <= hiscore_d;
      end
   end

   assign hiscore = hiscore_q;
`else
   assign hiscore = 16'h0000;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench for game_ctrl.
// A second instance with SCORE_DIV=1 reaches score saturation quickly.
module tb_game_ctrl;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        start = 1'b0;
   logic        start2 = 1'b0;
   logic        vs = 1'b0;
   logic        pxd = 1'b0;
   logic        pxc = 1'b0;
   logic        pz = 1'b0;

   logic        st1, ov1, ft1, st2, ov2, ft2;
   logic [3:0]  sp1, sp2;
   logic [15:0] sc1, sc2, hs1, hs2;

   int n_cmp = 0;
   int n_bad = 0;
   int frame_no = 0;

   typedef struct {
      int          frame;
      bit          sel;
      logic        st;
      logic        ov;
      logic [3:0]  sp;
      logic [15:0] sc;
      logic [15:0] hs;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   game_ctrl dut (
      .CLK(clk), .clrn(clrn), .start(start), .vs(vs),
      .px_dinosaur(pxd), .px_cactus(pxc),
      .game_status(st1), .game_over(ov1), .frame_tick(ft1),
      .speed(sp1), .score(sc1), .hiscore(hs1)
   );

   game_ctrl #(.SCORE_DIV(1)) dut2 (
      .CLK(clk), .clrn(clrn), .start(start2), .vs(vs),
      .px_dinosaur(pz), .px_cactus(pz),
      .game_status(st2), .game_over(ov2), .frame_tick(ft2),
      .speed(sp2), .score(sc2), .hiscore(hs2)
   );

   function automatic logic [15:0] hx(input logic [15:0] v);
`ifdef GAME_CTRL_HISCORE_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input int f, input bit sel, input logic s,
                       input logic o, input logic [3:0] sp,
                       input logic [15:0] sc, input logic [15:0] hs);
      exp_t e;
      e.frame = f; e.sel = sel; e.st = s; e.ov = o;
      e.sp = sp; e.sc = sc; e.hs = hs;
      q.push_back(e);
   endtask

   task automatic frame(input int h, input int ovl, input logic [1:0] stb);
      vs = 1'b1;
      for (int i = 0; i < h; i++) begin
         pxd = (i < ovl);
         pxc = (i < ovl);
         start = stb[0] && (i == 1);
         start2 = stb[1] && (i == 1);
         @(negedge clk);
      end
      pxd = 1'b0; pxc = 1'b0;
      start = 1'b0; start2 = 1'b0;
      vs = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_status"}, st1, 0);
      chk({tag, "_over"}, ov1, 0);
      chk({tag, "_tick"}, ft1, 0);
      chk({tag, "_speed"}, sp1, 1);
      chk({tag, "_score"}, sc1, 0);
      chk({tag, "_hiscore"}, hs1, 0);
      chk({tag, "_d2_status"}, st2, 0);
      chk({tag, "_d2_speed"}, sp2, 1);
      chk({tag, "_d2_score"}, sc2, 0);
   endtask

   // monitor: compare the snapshot one cycle after each frame tick
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ft1 === 1'b1) begin
            frame_no++;
            @(negedge clk);
            chk($sformatf("tick_width_f%0d", frame_no), ft1, 0);
            while (q.size() > 0 && q[0].frame <= frame_no) begin
               e = q.pop_front();
               if (e.sel) begin
                  chk($sformatf("d2_f%0d_status", e.frame), st2, e.st);
                  chk($sformatf("d2_f%0d_over", e.frame), ov2, e.ov);
                  chk($sformatf("d2_f%0d_speed", e.frame), sp2, e.sp);
                  chk($sformatf("d2_f%0d_score", e.frame), sc2, e.sc);
                  chk($sformatf("d2_f%0d_hiscore", e.frame), hs2, e.hs);
               end else begin
                  chk($sformatf("d1_f%0d_status", e.frame), st1, e.st);
                  chk($sformatf("d1_f%0d_over", e.frame), ov1, e.ov);
                  chk($sformatf("d1_f%0d_speed", e.frame), sp1, e.sp);
                  chk($sformatf("d1_f%0d_score", e.frame), sc1, e.sc);
                  chk($sformatf("d1_f%0d_hiscore", e.frame), hs1, e.hs);
               end
            end
         end
      end
   end

   initial begin
      int h, ovl;
      logic [1:0] stb;
      repeat (3) @(negedge clk);
      chk_reset("in_reset");
      clrn = 1'b1;
      @(negedge clk);
      chk_reset("after_reset");

      for (int f = 1; f <= 10011; f++) begin
         h = 3; ovl = 0; stb = 2'b00;
         case (f)
            4, 5:  stb = 2'b11;
            257:   begin h = 6; ovl = 3; end
            258:   begin h = 6; ovl = 4; end
            260:   stb = 2'b01;
            866:   begin h = 6; ovl = 4; end
            10011: stb = 2'b01;
            default: ;
         endcase
         case (f)
            1, 2, 3: push(f, 0, 0, 0, 1, 16'h0000, 16'h0000);
            4:     push(f, 0, 1, 0, 1, 16'h0000, 16'h0000);
            10:    push(f, 0, 1, 0, 1, 16'h0001, 16'h0000);
            256:   push(f, 0, 1, 0, 1, 16'h0042, 16'h0000);
            257:   push(f, 0, 1, 0, 1, 16'h0042, 16'h0000);
            258:   push(f, 0, 0, 1, 1, 16'h0042, hx(16'h0042));
            259:   push(f, 0, 0, 1, 1, 16'h0042, hx(16'h0042));
            260:   push(f, 0, 1, 0, 1, 16'h0000, hx(16'h0042));
            859:   push(f, 0, 1, 0, 1, 16'h0099, hx(16'h0042));
            860:   push(f, 0, 1, 0, 2, 16'h0100, hx(16'h0042));
            865:   push(f, 0, 1, 0, 2, 16'h0100, hx(16'h0042));
            866:   push(f, 0, 0, 1, 2, 16'h0100, hx(16'h0100));
            10011: push(f, 0, 1, 0, 1, 16'h0000, hx(16'h0100));
            default: ;
         endcase
         case (f)
            4:     push(f, 1, 1, 0, 1, 16'h0000, 16'h0000);
            103:   push(f, 1, 1, 0, 1, 16'h0099, 16'h0000);
            104:   push(f, 1, 1, 0, 2, 16'h0100, 16'h0000);
            10002: push(f, 1, 1, 0, 15, 16'h9998, 16'h0000);
            10003: push(f, 1, 1, 0, 15, 16'h9999, 16'h0000);
            10004: push(f, 1, 1, 0, 15, 16'h9999, 16'h0000);
            10011: push(f, 1, 1, 0, 15, 16'h9999, 16'h0000);
            default: ;
         endcase
         frame(h, ovl, stb);
      end

      repeat (4) @(negedge clk);
      chk("queue_drained", q.size(), 0);

      // both instances running: reset between clock edges
      vs = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_reset_d1_status", st1, 1);
      chk("pre_reset_d2_score", sc2, 16'h9999);
      #2 clrn = 1'b0;
      #1 chk_reset("async_reset");
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
